pipe_retire_monitor: RTL and testbench
======================================

PIPE_RETIRE_MONITOR -- requirements
Module: pipe_retire_monitor

Interface
REQ-001 Parameter XLEN, default 32, PC/data width.
REQ-002 Parameter DEPTH, default 8, in-flight tracking entries; power of two, >= 2.
REQ-003 Parameter TIMEOUT, default 64, cycles without a pop before hang is flagged; >= 2.
REQ-004 Parameter CNT_W, default 32, retire counter width.
REQ-005 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-006 reset_i  in  1  synchronous, active-high reset.
REQ-007 issue_valid_i  in  1  instruction accepted into the pipeline this cycle.
REQ-008 issue_pc_i  in  XLEN  PC of the issued instruction.
REQ-009 retire_valid_i  in  1  oldest in-flight instruction completes write-back.
REQ-010 kill_i  in  1  oldest in-flight instruction annulled (branch shadow); popped, not counted.
REQ-011 retire_valid_o  out  1  registered pulse, one cycle after an accepted retire.
REQ-012 retire_pc_o  out  XLEN  PC of the instruction flagged by retire_valid_o; holds its value otherwise.
REQ-013 occupancy_o  out  $clog2(DEPTH)+1  current in-flight count.
REQ-014 retired_cnt_o  out  CNT_W  accepted retires since reset.
REQ-015 err_overflow_o, err_underflow_o, err_protocol_o, err_hang_o  out  1 each  sticky error flags.
REQ-016 err_any_o  out  1  OR of the four sticky flags.

Function
REQ-017 In-order FIFO of DEPTH PCs; write pointer, read pointer and count wrap modulo DEPTH (pointers) / 0..DEPTH (count).
REQ-018 Push when issue_valid_i and (count < DEPTH or an accepted pop occurs in the same cycle).
REQ-019 Pop is accepted when exactly one of retire_valid_i/kill_i is high and count > 0.
REQ-020 Simultaneous push and accepted pop: count unchanged, both pointers advance; legal when full and when count = 1.
REQ-021 Push while full without an accepted pop: PC dropped, state unchanged, err_overflow_o set.
REQ-022 retire_valid_i or kill_i with count = 0: no pop, err_underflow_o set; a same-cycle push still occurs.
REQ-023 retire_valid_i and kill_i together: no pop, err_protocol_o set (regardless of count); a same-cycle push obeys REQ-018 without pop credit.
REQ-024 Accepted retire: next cycle retire_valid_o = 1, retire_pc_o = popped PC, retired_cnt_o incremented by 1, saturating at all-ones.
REQ-025 Accepted kill: no retire_valid_o pulse, counter unchanged.
REQ-026 Watchdog counter: cleared when count = 0 or on any accepted pop; otherwise increments, saturating at TIMEOUT.
REQ-027 err_hang_o set in the cycle after the watchdog reaches TIMEOUT (i.e. TIMEOUT consecutive cycles with count > 0 and no accepted pop).
REQ-028 All error flags sticky until reset; errors never block subsequent legal pushes/pops.
REQ-029 occupancy_o, retired_cnt_o and error flags are registered outputs; no combinational input-to-output paths.

Reset
REQ-030 While reset_i = 1 at a rising edge: pointers, count, watchdog, retired_cnt_o, retire_valid_o, retire_pc_o, all error flags cleared to 0; inputs ignored.
REQ-031 Reset asserted mid-operation discards all in-flight entries; first edge after deassertion behaves as from empty.

Verification
REQ-032 DEPTH=8: push PCs 0x100,0x104,0x108, then 3 retires -> retire_pc_o 0x100,0x104,0x108 one cycle after each, retired_cnt_o = 3, occupancy_o = 0.
REQ-033 Fill 8 entries, 9th push alone -> err_overflow_o = 1, occupancy_o = 8; then push+retire same cycle -> no new error, occupancy_o stays 8, oldest PC retired.
REQ-034 Empty, retire_valid_i = 1 -> err_underflow_o = 1, retire_valid_o = 0; retire+kill with count = 2 -> err_protocol_o = 1, occupancy_o = 2.
REQ-035 TIMEOUT=4: one push, no pops for 4 cycles -> err_hang_o = 1 on the 5th edge; kill pops without retire_valid_o pulse, retired_cnt_o unchanged.
REQ-036 Assert reset_i with 5 entries and all errors set -> all outputs 0 next cycle; subsequent push/retire of 0x200 -> retire_pc_o = 0x200, retired_cnt_o = 1.

Source files
------------

// File: rtl/pipe_retire_monitor_if.sv
// Issue/retire bus between a pipeline and its retire monitor.
// The master side drives issue/retire/kill; the slave (monitor) reports status.
interface pipe_retire_monitor_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 32
);
  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  logic             issue_valid_i;
  logic [XLEN-1:0]  issue_pc_i;
  logic             retire_valid_i;
  logic             kill_i;

  logic             retire_valid_o;
  logic [XLEN-1:0]  retire_pc_o;
  logic [OCC_W-1:0] occupancy_o;
  logic [CNT_W-1:0] retired_cnt_o;
  logic             err_overflow_o;
  logic             err_underflow_o;
  logic             err_protocol_o;
  logic             err_hang_o;
  logic             err_any_o;

  modport master (
    output issue_valid_i, issue_pc_i, retire_valid_i, kill_i,
    input  retire_valid_o, retire_pc_o, occupancy_o, retired_cnt_o,
    input  err_overflow_o, err_underflow_o, err_protocol_o, err_hang_o, err_any_o
  );

  modport slave (
    input  issue_valid_i, issue_pc_i, retire_valid_i, kill_i,
    output retire_valid_o, retire_pc_o, occupancy_o, retired_cnt_o,
    output err_overflow_o, err_underflow_o, err_protocol_o, err_hang_o, err_any_o
  );
endinterface

// File: rtl/pipe_retire_monitor.sv
// In-order retire monitor: tracks in-flight PCs in a FIFO, reports retired PCs,
// counts retires and raises sticky overflow/underflow/protocol/hang flags.
module pipe_retire_monitor #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 32
) (
  input logic                   clk_i,
  input logic                   reset_i,
  pipe_retire_monitor_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);

  logic [XLEN-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_count;
  logic [WD_W-1:0]  r_wd;
  logic             r_retire_valid;
  logic [XLEN-1:0]  r_retire_pc;
  logic [CNT_W-1:0] r_retired_cnt;
  logic             r_err_overflow;
  logic             r_err_underflow;
  logic             r_err_protocol;
  logic             r_err_hang;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_overflow;
  logic w_underflow;
  logic w_protocol;

  // Decode this cycle's push/pop and error conditions.
  always_comb begin
    w_empty     = (r_count == '0);
    w_full      = (r_count == FULL_CNT);
    // Exactly one of retire/kill pops; both together is a protocol error, never a pop.
    w_pop       = (bus.retire_valid_i ^ bus.kill_i) && !w_empty;
    // A same-cycle pop frees a slot, so a full FIFO can still accept.
    w_push      = bus.issue_valid_i && (!w_full || w_pop);
    w_overflow  = bus.issue_valid_i && !w_push;
    w_underflow = (bus.retire_valid_i || bus.kill_i) && w_empty;
    w_protocol  = bus.retire_valid_i && bus.kill_i;
  end

  // PC storage; contents are don't-care outside the occupied window, so no reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i && w_push) begin
      r_mem[r_wr_ptr] <= bus.issue_pc_i;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + OCC_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - OCC_W'(1);
    end
  end

  // Watchdog: counts cycles with work in flight but no progress, saturating at TIMEOUT.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wd <= '0;
    end else if (w_empty || w_pop) begin
      r_wd <= '0;
    end else if (r_wd != WD_MAX) begin
      r_wd <= r_wd + WD_W'(1);
    end
  end

  // Retire report: one-cycle pulse with the popped PC; kills are silent.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_retire_valid <= 1'b0;
      r_retire_pc    <= '0;
      r_retired_cnt  <= '0;
    end else begin
      r_retire_valid <= w_pop && bus.retire_valid_i;
      if (w_pop && bus.retire_valid_i) begin
        r_retire_pc <= r_mem[r_rd_ptr];
        if (r_retired_cnt != '1) r_retired_cnt <= r_retired_cnt + CNT_W'(1);
      end
    end
  end

  // Sticky error flags; they never gate the datapath.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
      r_err_protocol  <= 1'b0;
      r_err_hang      <= 1'b0;
    end else begin
      if (w_overflow)      r_err_overflow  <= 1'b1;
      if (w_underflow)     r_err_underflow <= 1'b1;
      if (w_protocol)      r_err_protocol  <= 1'b1;
      if (r_wd == WD_MAX)  r_err_hang      <= 1'b1;
    end
  end

  assign bus.retire_valid_o  = r_retire_valid;
  assign bus.retire_pc_o     = r_retire_pc;
  assign bus.occupancy_o     = r_count;
  assign bus.retired_cnt_o   = r_retired_cnt;
  assign bus.err_overflow_o  = r_err_overflow;
  assign bus.err_underflow_o = r_err_underflow;
  assign bus.err_protocol_o  = r_err_protocol;
  assign bus.err_hang_o      = r_err_hang;
  assign bus.err_any_o       = r_err_overflow | r_err_underflow | r_err_protocol | r_err_hang;

endmodule

// File: tb/tb_pipe_retire_monitor.sv
// Directed, table-driven bench for pipe_retire_monitor (DEPTH=8, TIMEOUT=4, CNT_W=4).
module tb_pipe_retire_monitor;

  logic clk;
  logic reset;

  pipe_retire_monitor_if #(.XLEN(32), .DEPTH(8), .CNT_W(4)) bus ();

  pipe_retire_monitor #(
    .XLEN   (32),
    .DEPTH  (8),
    .TIMEOUT(4),
    .CNT_W  (4)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] pc;
    logic        rv;
    logic        kl;
    logic        e_rv;
    logic [31:0] e_pc;
    logic [3:0]  e_occ;
    logic [3:0]  e_cnt;
    logic [3:0]  e_err;  // {hang, protocol, underflow, overflow}
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void add(input logic rst, input logic iv, input logic [31:0] pc,
                              input logic rv, input logic kl, input logic e_rv,
                              input logic [31:0] e_pc, input logic [3:0] e_occ,
                              input logic [3:0] e_cnt, input logic [3:0] e_err);
    vec_t v;
    v.rst = rst; v.iv = iv; v.pc = pc; v.rv = rv; v.kl = kl;
    v.e_rv = e_rv; v.e_pc = e_pc; v.e_occ = e_occ; v.e_cnt = e_cnt; v.e_err = e_err;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_rv, input logic [31:0] e_pc,
                           input logic [3:0] e_occ, input logic [3:0] e_cnt,
                           input logic [3:0] e_err);
    logic [3:0] err;
    err = {bus.err_hang_o, bus.err_protocol_o, bus.err_underflow_o, bus.err_overflow_o};
    check({tag, ".retire_valid"}, 64'(bus.retire_valid_o), 64'(e_rv));
    check({tag, ".retire_pc"},    64'(bus.retire_pc_o),    64'(e_pc));
    check({tag, ".occupancy"},    64'(bus.occupancy_o),    64'(e_occ));
    check({tag, ".retired_cnt"},  64'(bus.retired_cnt_o),  64'(e_cnt));
    check({tag, ".err_flags"},    64'(err),                64'(e_err));
    check({tag, ".err_any"},      64'(bus.err_any_o),      64'(e_err != 4'b0));
  endtask

  // Drive inputs away from the edge, then sample just after the rising edge.
  task automatic step(input logic rst, input logic iv, input logic [31:0] pc,
                      input logic rv, input logic kl);
    @(negedge clk);
    reset              = rst;
    bus.issue_valid_i  = iv;
    bus.issue_pc_i     = pc;
    bus.retire_valid_i = rv;
    bus.kill_i         = kl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset              = 1'b1;
    bus.issue_valid_i  = 1'b0;
    bus.issue_pc_i     = '0;
    bus.retire_valid_i = 1'b0;
    bus.kill_i         = 1'b0;

    // rst iv pc rv kl | rv pc occ cnt err
    add(1, 0, 32'h0,   0, 0,  0, 32'h0,   0, 0, 4'b0000);  // reset state
    add(0, 1, 32'h100, 0, 0,  0, 32'h0,   1, 0, 4'b0000);  // in-order retire
    add(0, 1, 32'h104, 0, 0,  0, 32'h0,   2, 0, 4'b0000);
    add(0, 1, 32'h108, 0, 0,  0, 32'h0,   3, 0, 4'b0000);
    add(0, 0, 32'h0,   1, 0,  1, 32'h100, 2, 1, 4'b0000);
    add(0, 0, 32'h0,   1, 0,  1, 32'h104, 1, 2, 4'b0000);
    add(0, 0, 32'h0,   1, 0,  1, 32'h108, 0, 3, 4'b0000);
    add(0, 0, 32'h0,   0, 0,  0, 32'h108, 0, 3, 4'b0000);  // pc holds, pulse ends
    add(0, 0, 32'h0,   1, 0,  0, 32'h108, 0, 3, 4'b0010);  // underflow
    add(0, 1, 32'h10C, 0, 1,  0, 32'h108, 1, 3, 4'b0010);  // kill on empty, push still lands
    add(0, 1, 32'h110, 0, 0,  0, 32'h108, 2, 3, 4'b0010);
    add(0, 0, 32'h0,   1, 1,  0, 32'h108, 2, 3, 4'b0110);  // retire+kill: protocol, no pop
    add(0, 0, 32'h0,   0, 1,  0, 32'h108, 1, 3, 4'b0110);  // kill pops 0x10C silently
    add(0, 1, 32'h114, 1, 0,  1, 32'h110, 1, 4, 4'b0110);  // push+retire at count 1
    add(0, 0, 32'h0,   1, 0,  1, 32'h114, 0, 5, 4'b0110);
    add(1, 1, 32'h999, 1, 0,  0, 32'h0,   0, 0, 4'b0000);  // reset ignores inputs
    // Fill; the watchdog runs with no pops and trips hang after the 6th push.
    for (int i = 0; i < 8; i++)
      add(0, 1, 32'h300 + 32'(4 * i), 0, 0, 0, 32'h0, 4'(i + 1), 0,
          (i >= 5) ? 4'b1000 : 4'b0000);
    add(0, 1, 32'h320, 0, 0,  0, 32'h0,   8, 0, 4'b1001);  // overflow, PC dropped
    add(0, 1, 32'h324, 1, 0,  1, 32'h300, 8, 1, 4'b1001);  // push+retire when full
    add(1, 0, 32'h0,   0, 0,  0, 32'h0,   0, 0, 4'b0000);
    add(0, 1, 32'h400, 0, 0,  0, 32'h0,   1, 0, 4'b0000);  // hang timing
    add(0, 0, 32'h0,   0, 0,  0, 32'h0,   1, 0, 4'b0000);
    add(0, 0, 32'h0,   0, 0,  0, 32'h0,   1, 0, 4'b0000);
    add(0, 0, 32'h0,   0, 0,  0, 32'h0,   1, 0, 4'b0000);
    add(0, 0, 32'h0,   0, 0,  0, 32'h0,   1, 0, 4'b0000);
    add(0, 0, 32'h0,   0, 0,  0, 32'h0,   1, 0, 4'b1000);  // 5th edge after the push
    add(0, 0, 32'h0,   0, 1,  0, 32'h0,   0, 0, 4'b1000);  // kill: no pulse, cnt unchanged
    add(1, 0, 32'h0,   0, 0,  0, 32'h0,   0, 0, 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].iv, vecs[i].pc, vecs[i].rv, vecs[i].kl);
      check_all($sformatf("vec%0d", i), vecs[i].e_rv, vecs[i].e_pc, vecs[i].e_occ,
                vecs[i].e_cnt, vecs[i].e_err);
    end

    // Load 5 entries with every error flag raised, then reset mid-operation.
    step(0, 0, 32'h0, 1, 0);
    step(0, 0, 32'h0, 1, 1);
    for (int i = 0; i < 9; i++) step(0, 1, 32'h500 + 32'(4 * i), 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 1, 0);
    check_all("seqA_loaded", 1'b1, 32'h508, 4'd5, 4'd3, 4'b1111);
    step(1, 0, 32'h0, 0, 0);
    check_all("seqA_reset", 1'b0, 32'h0, 4'd0, 4'd0, 4'b0000);
    step(0, 1, 32'h200, 0, 0);
    check_all("seqA_push", 1'b0, 32'h0, 4'd1, 4'd0, 4'b0000);
    step(0, 0, 32'h0, 1, 0);
    check_all("seqA_retire", 1'b1, 32'h200, 4'd0, 4'd1, 4'b0000);

    // Retire counter saturation (CNT_W=4 saturates at 15).
    step(1, 0, 32'h0, 0, 0);
    step(0, 1, 32'h600, 0, 0);
    for (int k = 0; k < 16; k++) begin
      step(0, 1, 32'h604 + 32'(4 * k), 1, 0);
      check($sformatf("seqB_cnt%0d", k), 64'(bus.retired_cnt_o),
            64'((k + 1 > 15) ? 15 : k + 1));
      check($sformatf("seqB_pc%0d", k), 64'(bus.retire_pc_o), 64'(32'h600 + 32'(4 * k)));
    end
    step(0, 0, 32'h0, 1, 0);
    check_all("seqB_final", 1'b1, 32'h640, 4'd0, 4'd15, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
